// File: rtl/kim_fifo_pkg.sv
// rtl/kim_fifo_pkg.sv - shared constants and helpers for the kim_fifo_sync FIFO
package kim_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Occupancy needs one extra bit so that DEPTH itself is representable.
    function automatic int cnt_width(input int log2_depth);
        return log2_depth + 1;
    endfunction

endpackage

// File: rtl/kim_fifo_ptr.sv
// rtl/kim_fifo_ptr.sv - FIFO pointer with wrap bit; wraps at DEPTH-1 for any DEPTH
module kim_fifo_ptr
    import kim_fifo_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOG2_DEPTH = clog2(DEF_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_inc,
    output logic [LOG2_DEPTH-1:0] o_ptr,
    output logic                  o_wrap
);

    localparam logic [LOG2_DEPTH-1:0] LAST = LOG2_DEPTH'(DEPTH - 1);

    logic [LOG2_DEPTH-1:0] r_ptr;
    logic                  r_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_ptr  <= '0;
            r_wrap <= 1'b0;
        end else if (i_inc) begin
            if (r_ptr == LAST) begin
                r_ptr  <= '0;
                r_wrap <= ~r_wrap;
            end else begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign o_ptr  = r_ptr;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/kim_fifo_sync.sv
// rtl/kim_fifo_sync.sv - single-clock FWFT FIFO with handshakes, thresholds and flush
// Define KIM_FIFO_ERR_FLAG_EN to build the sticky ovf_err/udf_err flags.
module kim_fifo_sync
    import kim_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LOG2_DEPTH = clog2(DEF_DEPTH),
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LOG2_DEPTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam int CNT_W = cnt_width(LOG2_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_count;

    logic [LOG2_DEPTH-1:0] w_wr_ptr;
    logic [LOG2_DEPTH-1:0] w_rd_ptr;
    logic                  w_wr_wrap;
    logic                  w_rd_wrap;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_fire;
    logic                  w_rd_fire;

    assign w_full  = (w_wr_ptr == w_rd_ptr) && (w_wr_wrap != w_rd_wrap);
    assign w_empty = (w_wr_ptr == w_rd_ptr) && (w_wr_wrap == w_rd_wrap);

    // Flush suppresses both fires so a concurrent write never lands in storage.
    assign w_wr_fire = s_valid && !w_full && !flush;
    assign w_rd_fire = m_ready && !w_empty && !flush;

    kim_fifo_ptr #(
        .DEPTH      (DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_wr_ptr (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_inc   (w_wr_fire),
        .o_ptr   (w_wr_ptr),
        .o_wrap  (w_wr_wrap)
    );

    kim_fifo_ptr #(
        .DEPTH      (DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_rd_ptr (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_inc   (w_rd_fire),
        .o_ptr   (w_rd_ptr),
        .o_wrap  (w_rd_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_mem[w_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else if (w_wr_fire && !w_rd_fire) begin
            r_count <= r_count + 1'b1;
        end else if (w_rd_fire && !w_wr_fire) begin
            r_count <= r_count - 1'b1;
        end
    end

`ifdef KIM_FIFO_ERR_FLAG_EN
    logic r_ovf_err;
    logic r_udf_err;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (s_valid && w_full) begin
                r_ovf_err <= 1'b1;
            end
            if (m_ready && w_empty) begin
                r_udf_err <= 1'b1;
            end
        end
    end

    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

    assign s_ready      = ~w_full;
    assign m_valid      = ~w_empty;
    assign m_data       = r_mem[w_rd_ptr];
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_W'(AFULL_TH));
    assign almost_empty = (r_count <= CNT_W'(AEMPTY_TH));

endmodule

// File: tb/tb_kim_fifo_sync.sv
// tb/tb_kim_fifo_sync.sv - self-checking bench for kim_fifo_sync (DEPTH=4)
module tb_kim_fifo_sync;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF_TH = 3;
    localparam int AE_TH = 1;
`ifdef KIM_FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [2:0]    count;
    logic          full, empty, almost_full, almost_empty, ovf_err, udf_err;

    always #5 clk = ~clk;

    kim_fifo_sync #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .LOG2_DEPTH (2),
        .AFULL_TH   (AF_TH),
        .AEMPTY_TH  (AE_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a queue of words plus sticky error bits.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_udf;

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_edge(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
        int sz;
        sz = q.size();
        if (fl) begin
            model_clear();
        end else begin
            if (ERR_EN && sv && sz == DEPTH) m_ovf = 1'b1;
            if (ERR_EN && mr && sz == 0)     m_udf = 1'b1;
            if (mr && sz > 0)                void'(q.pop_front());
            if (sv && sz < DEPTH)            q.push_back(sd);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".count"}, 32'(count), 32'(sz));
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(sz > 0));
        if (sz > 0) chk({tag, ".m_data"}, 32'(m_data), 32'(q[0]));
        chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(sz != DEPTH));
        chk({tag, ".afull"}, 32'(almost_full), 32'(sz >= AF_TH));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= AE_TH));
        chk({tag, ".ovf"}, 32'(ovf_err), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(udf_err), 32'(m_udf));
    endtask

    task automatic step(input string tag, input logic sv, input logic [DW-1:0] sd,
                        input logic mr, input logic fl);
        check_model(tag);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        flush   = fl;
        model_edge(sv, sd, mr, fl);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          fl;
        int            cnt;
        logic          mv;
        logic [DW-1:0] md;
        logic          fu;
        logic          af;
        logic          ae;
    } vec_t;

    vec_t vecs[16];

    initial begin
        //        sv    sd     mr    fl    cnt mv    md     full  af    ae
        vecs[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 2, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 3, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 4, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'hEE, 1'b1, 1'b0, 3, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 4, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 8'h12, 1'b0, 1'b0, 2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'h13, 1'b0, 1'b0, 3, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'h99, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        @(negedge clk);
        do_reset();
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.s_ready", 32'(s_ready), 32'd1);
        chk("rst.m_valid", 32'(m_valid), 32'd0);
        chk("rst.m_data", 32'(m_data), 32'd0);
        chk("rst.aempty", 32'(almost_empty), 32'd1);
        chk("rst.afull", 32'(almost_full), 32'd0);
        chk("rst.ovf", 32'(ovf_err), 32'd0);
        chk("rst.udf", 32'(udf_err), 32'd0);

        for (int i = 0; i < 16; i++) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            flush   = vecs[i].fl;
            @(posedge clk);
            @(negedge clk);
            s_valid = 1'b0;
            m_ready = 1'b0;
            flush   = 1'b0;
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d.m_valid", i), 32'(m_valid), 32'(vecs[i].mv));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(!vecs[i].mv));
            if (vecs[i].mv) chk($sformatf("vec%0d.m_data", i), 32'(m_data), 32'(vecs[i].md));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].fu));
            chk($sformatf("vec%0d.s_ready", i), 32'(s_ready), 32'(!vecs[i].fu));
            chk($sformatf("vec%0d.afull", i), 32'(almost_full), 32'(vecs[i].af));
            chk($sformatf("vec%0d.aempty", i), 32'(almost_empty), 32'(vecs[i].ae));
        end

        // Interleaved traffic, then sustained read+write at count=2 across pointer wraps.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step("wrap_wr", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            step("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        step("wrap_fill", 1'b1, 8'h30, 1'b0, 1'b0);
        step("wrap_fill", 1'b1, 8'h31, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("hold.count", 32'(count), 32'd2);
            step("hold", 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        end
        check_model("hold_end");

        // Error flags: overflow while full, underflow while empty, cleared by flush.
        do_reset();
        for (int i = 0; i < 4; i++) step("err_fill", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step("err_ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf_err), 32'(ERR_EN));
        for (int i = 0; i < 4; i++) step("err_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("err_udf", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set", 32'(udf_err), 32'(ERR_EN));
        chk("ovf_sticky", 32'(ovf_err), 32'(ERR_EN));
        step("err_flush", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf_err), 32'd0);
        chk("udf_clr", 32'(udf_err), 32'd0);

        // Reset mid-stream discards contents; next word lands at entry 0.
        do_reset();
        step("mid_wr", 1'b1, 8'h71, 1'b0, 1'b0);
        step("mid_wr", 1'b1, 8'h72, 1'b0, 1'b0);
        do_reset();
        chk("mid.count", 32'(count), 32'd0);
        chk("mid.m_valid", 32'(m_valid), 32'd0);
        chk("mid.full", 32'(full), 32'd0);
        chk("mid.afull", 32'(almost_full), 32'd0);
        chk("mid.ovf", 32'(ovf_err), 32'd0);
        step("mid_post", 1'b1, 8'h77, 1'b0, 1'b0);
        chk("mid.m_data", 32'(m_data), 32'h77);

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 60),
                 8'($urandom),
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 3));
        end
        check_model("rand_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kim_fifo_sync.md
Name: kim_fifo_sync

Overview:
- Single-clock synchronous FIFO with storage and control in one block. Successor to the pointer/storage block.
- Adds valid/ready handshakes on both sides, full/empty, occupancy count, almost-full/almost-empty thresholds and a synchronous flush.
- Sits between stream producers and consumers inside one clock domain. Output is first-word-fall-through (FWFT).

Parameters:
- DATA_WIDTH, 32, width of a data word.
- DEPTH, 16, number of entries; any value >= 2, power of two not required.
- LOG2_DEPTH, 4, pointer width; must equal ceil(log2(DEPTH)).
- AFULL_TH, 12, almost_full asserted when count >= AFULL_TH; range 1..DEPTH.
- AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH; range 0..DEPTH-1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of FIFO contents; pointers and count only.
- s_valid  in  1  write request.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  DATA_WIDTH  write data.
- m_valid  out  1  head word available.
- m_ready  in  1  consumer accepts head word.
- m_data  out  DATA_WIDTH  head word (FWFT).
- count  out  LOG2_DEPTH+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- ovf_err  out  1  sticky overflow flag; optional feature.
- udf_err  out  1  sticky underflow flag; optional feature.

Behaviour:
- Reset and clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (rst=1 at a clock edge):
  - w_ptr, r_ptr, both wrap bits and count = 0.
  - All storage entries = 0.
  - empty=1, full=0, s_ready=1, m_valid=0, m_data=0, almost_empty=1.
  - almost_full=0 (AFULL_TH >= 1).
  - ovf_err=0, udf_err=0.
- Handshakes:
  - s_ready = ~full.
  - Write fires on s_valid & s_ready; data is written at w_ptr on that edge.
  - m_valid = ~empty; m_data = mem[r_ptr] combinationally.
  - Read fires on m_valid & m_ready.
- Latency: a word written at edge N is visible on m_data/m_valid after edge N. Write-to-read latency is 1 cycle; there is no same-cycle bypass when empty.
- Pointers:
  - Each pointer advances by 1 per fire.
  - At DEPTH-1 it wraps to 0 and toggles its wrap bit.
  - full = (w_ptr==r_ptr) & (w_wrap!=r_wrap); empty = (w_ptr==r_ptr) & (w_wrap==r_wrap).
- Count update:
  - +1 on write only; -1 on read only; unchanged on both or neither.
  - Never leaves 0..DEPTH.
- Simultaneous events:
  - Read+write while 0 < count < DEPTH: both pointers advance and count is held.
  - When full: write blocked (s_ready=0), read proceeds, and s_ready rises next cycle.
  - When empty: read blocked, write proceeds.
- Flags: full, empty, almost_full and almost_empty are derived from the registered pointers/count, with no combinational path from s_valid/m_ready.
- Flush:
  - Clears pointers, wrap bits and count next edge.
  - Storage is not cleared.
  - Has priority over any same-cycle fire; a concurrent write is dropped.
  - Also clears ovf_err/udf_err.
- rst has priority over flush.
- Reset mid-operation discards all contents; the first post-reset word lands at entry 0.

Optional Feature:
- Macro: KIM_FIFO_ERR_FLAG_EN.
- Defined:
  - ovf_err sets on any edge with s_valid & full.
  - udf_err sets on any edge with m_ready & empty.
  - Both are sticky until rst or flush.
- Undefined: ovf_err and udf_err are tied to 0, with no flag registers synthesised. The port list is unchanged.

Decomposition:
- Package kim_fifo_pkg:
  - clog2 constant function.
  - Default DATA_WIDTH/DEPTH constants.
  - Count-width rule LOG2_DEPTH+1.
- Sub-module kim_fifo_ptr:
  - Pointer plus wrap-bit counter with inc, flush and rst inputs; parameters DEPTH, LOG2_DEPTH.
  - Instantiated twice, for write and read.
- Storage, flags and count stay in the top.

Test Plan:
- DEPTH=4, AFULL_TH=3, AEMPTY_TH=1. rst, then write 0xA0..0xA3 with m_ready=0:
  - count 1,2,3,4.
  - almost_full at count=3.
  - full=1, s_ready=0 after the 4th write.
  - m_data=0xA0 throughout.
- Full FIFO, m_ready=1 for 4 cycles:
  - Reads 0xA0,0xA1,0xA2,0xA3.
  - empty=1 and count=0 after the 4th read.
  - almost_empty at count<=1.
- Wrap: 6 writes interleaved with 6 reads, then a sustained simultaneous read+write at count=2 for 10 cycles:
  - count held at 2.
  - Order preserved across two pointer wraps.
- Full with s_valid=1 and m_ready=1 in the same cycle:
  - Only the read fires; count 4->3.
  - Next cycle the write is accepted and count returns to 4.
- count=3, flush=1 with a concurrent s_valid=1:
  - Next cycle count=0, empty=1, and the write is dropped.
  - A following write of 0x55 appears on m_data.
- With KIM_FIFO_ERR_FLAG_EN: s_valid while full -> ovf_err=1; m_ready while empty -> udf_err=1. Both stay set until flush, then 0.
- rst mid-stream: rst=1 at count=2 -> count=0, m_valid=0, flags 0.
